// File: rtl/dmem_bus_arbiter.sv
// Shares one fixed-latency data-memory port between NUM_CORES L1 caches.
// Round-robin by default; define DMEM_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module dmem_bus_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES-1:0]          done,
    output logic [DATA_W-1:0]             rdata,
    output logic                          mem_rd_en,
    output logic                          mem_wr_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [IDX_W:0] NC_W = (IDX_W+1)'(NUM_CORES);
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_reg;
    logic [IDX_W-1:0]       owner_reg;
    logic [3:0]             lat_cnt_reg;
    logic                   txn_we_reg;
    logic [ADDR_W-1:0]      txn_addr_reg;
    logic [DATA_W-1:0]      txn_wdata_reg;
    logic [DATA_W-1:0]      rdata_q;
    logic [NUM_CORES-1:0]   gnt_reg;
    logic [NUM_CORES-1:0]   done_reg;

    logic [ADDR_W-1:0]      addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]      wdata_arr [NUM_CORES];
    logic [NUM_CORES-1:0]   win_onehot;
    logic [NUM_CORES-1:0]   rot_req;
    logic [IDX_W-1:0]       win_off;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         win_sum;
    logic                   last_access;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_slice
            assign addr_arr[gi]   = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]  = wdata[gi*DATA_W +: DATA_W];
            assign win_onehot[gi] = (win_idx == IDX_W'(gi));
        end
    endgenerate

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    assign rot_req = req;
    assign win_sum = {1'b0, win_off};
`else
    logic [IDX_W-1:0] rr_ptr_reg;
    // Rotate so that bit 0 is the core rr_ptr points at; the lowest set bit then wins.
    assign rot_req = NUM_CORES'({req, req} >> rr_ptr_reg);
    assign win_sum = {1'b0, rr_ptr_reg} + {1'b0, win_off};
`endif

    always_comb begin
        win_off = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                win_off = IDX_W'(j);
            end
        end
    end

    assign win_idx = (win_sum >= NC_W) ? IDX_W'(win_sum - NC_W) : IDX_W'(win_sum);

    assign last_access = (state_reg == ACCESS) && (lat_cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            lat_cnt_reg   <= '0;
            txn_we_reg    <= 1'b0;
            txn_addr_reg  <= '0;
            txn_wdata_reg <= '0;
            rdata_q       <= '0;
            gnt_reg       <= '0;
            done_reg      <= '0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
            rr_ptr_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= '0;
                    if (req != '0) begin
                        state_reg     <= ACCESS;
                        owner_reg     <= win_idx;
                        gnt_reg       <= win_onehot;
                        txn_we_reg    <= we[win_idx];
                        txn_addr_reg  <= addr_arr[win_idx];
                        txn_wdata_reg <= wdata_arr[win_idx];
                        lat_cnt_reg   <= '0;
                    end
                end
                ACCESS: begin
                    lat_cnt_reg <= lat_cnt_reg + 4'd1;
                    if (lat_cnt_reg == LAST_CNT) begin
                        if (!txn_we_reg) begin
                            rdata_q <= mem_rdata;
                        end
                        done_reg  <= gnt_reg;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    done_reg  <= '0;
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
                    rr_ptr_reg <= (owner_reg == IDX_W'(NUM_CORES - 1)) ? '0 : owner_reg + 1'b1;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign rdata     = (state_reg == RESP) ? rdata_q : '0;
    assign mem_rd_en = (state_reg == ACCESS) && !txn_we_reg;
    // Gated by reset so an abandoned write never reaches memory, even in the reset cycle.
    assign mem_wr_en = last_access && txn_we_reg && !reset;
    assign mem_addr  = (state_reg == ACCESS) ? txn_addr_reg : '0;
    assign mem_wdata = (state_reg == ACCESS) ? txn_wdata_reg : '0;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Bench for dmem_bus_arbiter: cycle table on a MEM_LAT=1 instance plus a MEM_LAT=3 read sequence.
module tb_dmem_bus_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // MEM_LAT = 1 instance
    logic        reset = 1'b1;
    logic [1:0]  req = '0, we = '0;
    logic [19:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [1:0]  gnt, done;
    logic [31:0] rdata, mem_wdata;
    logic        mem_rd_en, mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    // MEM_LAT = 3 instance
    logic        reset3 = 1'b1;
    logic [1:0]  req3 = '0, we3 = '0;
    logic [19:0] addr3 = '0;
    logic [63:0] wdata3 = '0;
    logic [1:0]  gnt3, done3;
    logic [31:0] rdata3, mem_wdata3;
    logic        mem_rd_en3, mem_wr_en3;
    logic [9:0]  mem_addr3;
    logic [31:0] mem_rdata3 = '0;

    dmem_bus_arbiter #(.NUM_CORES(2), .ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .done(done), .rdata(rdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_bus_arbiter #(.NUM_CORES(2), .ADDR_W(10), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
        .gnt(gnt3), .done(done3), .rdata(rdata3), .mem_rd_en(mem_rd_en3), .mem_wr_en(mem_wr_en3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req, we;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1, mrd;
        logic [1:0]  gnt, done;
        logic [31:0] rdata;
        logic        rd, wr;
        logic [9:0]  maddr;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int checks = 0;
    int errors = 0;

`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    localparam logic [1:0] G_ALT = 2'b01;
    localparam logic [9:0] A_ALT = 10'h011;
`else
    localparam logic [1:0] G_ALT = 2'b10;
    localparam logic [9:0] A_ALT = 10'h022;
`endif

    function automatic vec_t mk(input logic rst, input logic [1:0] rq, input logic [1:0] w,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] mrd,
                                input logic [1:0] g, input logic [1:0] dn, input logic [31:0] rdt,
                                input logic rd, input logic wr, input logic [9:0] ma, input logic [31:0] mw);
        vec_t v;
        v.rst = rst; v.req = rq; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.mrd = mrd;
        v.gnt = g; v.done = dn; v.rdata = rdt; v.rd = rd; v.wr = wr; v.maddr = ma; v.mwdata = mw;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        // reset, then core0 read of 0x005
        vecs.push_back(mk(1, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h005, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h005, 10'h000, 0, 0, 32'hDEADBEEF, 2'b01, 2'b00, 0,            1, 0, 10'h005, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h005, 10'h000, 0, 0, 0,            2'b01, 2'b01, 32'hDEADBEEF, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        // reset, then core1 write to 0x3FF
        vecs.push_back(mk(1, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b10, 2'b10, 10'h000, 10'h3FF, 0, 32'h12345678, 0, 2'b00, 2'b00, 0, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b10, 2'b10, 10'h000, 10'h3FF, 0, 32'h12345678, 0, 2'b10, 2'b00, 0, 0, 1, 10'h3FF, 32'h12345678));
        vecs.push_back(mk(0, 2'b10, 2'b10, 10'h000, 10'h3FF, 0, 32'h12345678, 0, 2'b10, 2'b10, 0, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0, 0, 0, 10'h000, 0));
        // reset, then both cores request continuously
        vecs.push_back(mk(1, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 32'h0A0A0A0A, 2'b01, 2'b00, 0,            1, 0, 10'h011, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b01, 2'b01, 32'h0A0A0A0A, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 32'h0B0B0B0B, G_ALT, 2'b00, 0,            1, 0, A_ALT,   0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            G_ALT, G_ALT, 32'h0B0B0B0B, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 32'h0C0C0C0C, 2'b01, 2'b00, 0,            1, 0, 10'h011, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b01, 2'b01, 32'h0C0C0C0C, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 32'h0D0D0D0D, G_ALT, 2'b00, 0,            1, 0, A_ALT,   0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h011, 10'h022, 0, 0, 0,            G_ALT, G_ALT, 32'h0D0D0D0D, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        // core1 arrives while core0 is in ACCESS; its inputs must not disturb core0
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h100, 10'h200, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h100, 10'h2AA, 0, 0, 32'h11111111, 2'b01, 2'b00, 0,            1, 0, 10'h100, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h100, 10'h2AA, 0, 0, 0,            2'b01, 2'b01, 32'h11111111, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 10'h000, 10'h2AA, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 10'h000, 10'h2AA, 0, 0, 32'h22222222, 2'b10, 2'b00, 0,            1, 0, 10'h2AA, 0));
        vecs.push_back(mk(0, 2'b10, 2'b00, 10'h000, 10'h2AA, 0, 0, 0,            2'b10, 2'b10, 32'h22222222, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        // core0 read moves rr_ptr to 1, then reset aborts a core0 write mid-ACCESS
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h050, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h050, 10'h000, 0, 0, 32'h33333333, 2'b01, 2'b00, 0,            1, 0, 10'h050, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 10'h050, 10'h000, 0, 0, 0,            2'b01, 2'b01, 32'h33333333, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 10'h060, 10'h000, 32'h55AA55AA, 0, 0, 2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 10'h060, 10'h000, 32'h55AA55AA, 0, 0, 2'b01, 2'b00, 0,            0, 0, 10'h060, 32'h55AA55AA));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h070, 10'h080, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h070, 10'h080, 0, 0, 32'h44444444, 2'b01, 2'b00, 0,            1, 0, 10'h070, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 10'h070, 10'h080, 0, 0, 0,            2'b01, 2'b01, 32'h44444444, 0, 0, 10'h000, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 0, 0, 0,            2'b00, 2'b00, 0,            0, 0, 10'h000, 0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            req       = vecs[i].req;
            we        = vecs[i].we;
            addr      = {vecs[i].a1, vecs[i].a0};
            wdata     = {vecs[i].d1, vecs[i].d0};
            mem_rdata = vecs[i].mrd;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check("gnt",       i, 32'(gnt),       32'(e.gnt));
            check("done",      i, 32'(done),      32'(e.done));
            check("rdata",     i, rdata,          e.rdata);
            check("mem_rd_en", i, 32'(mem_rd_en), 32'(e.rd));
            check("mem_wr_en", i, 32'(mem_wr_en), 32'(e.wr));
            check("mem_addr",  i, 32'(mem_addr),  32'(e.maddr));
            check("mem_wdata", i, mem_wdata,      e.mwdata);
            $display("vec %0d rst=%b req=%b gnt=%b done=%b rdata=%h rd=%b wr=%b maddr=%h",
                     i, e.rst, e.req, gnt, done, rdata, mem_rd_en, mem_wr_en, mem_addr);
        end

        // MEM_LAT=3 read: memory data changes every cycle, only the last ACCESS value is kept
        begin
            int rd_cnt = 0;
            int wr_cnt = 0;
            int done_k = -1;
            logic [31:0] rd_val = '0;
            logic [1:0]  done_v = '0;
            @(posedge clk);
            #1;
            reset3     = 1'b0;
            req3       = 2'b01;
            we3        = 2'b00;
            addr3      = {10'h000, 10'h123};
            mem_rdata3 = 32'hC0DE0000;
            for (int k = 0; k < 20 && done_k < 0; k++) begin
                @(negedge clk);
                if (mem_rd_en3) begin
                    rd_cnt++;
                    check("lat3_mem_addr", k, 32'(mem_addr3), 32'h123);
                end
                if (mem_wr_en3) wr_cnt++;
                if (done3 != 2'b00) begin
                    done_k = k;
                    rd_val = rdata3;
                    done_v = done3;
                end
                @(posedge clk);
                #1;
                mem_rdata3 = 32'hC0DE0000 | 32'(k + 1);
                if (done_k >= 0) req3 = 2'b00;
            end
            check("lat3_rd_cycles", 0, 32'(rd_cnt), 32'd3);
            check("lat3_wr_cycles", 0, 32'(wr_cnt), 32'd0);
            check("lat3_done_cycle", 0, 32'(done_k), 32'd4);
            check("lat3_done", 0, 32'(done_v), 32'h1);
            check("lat3_rdata", 0, rd_val, 32'hC0DE0003);
            $display("lat3 read done at cycle %0d rdata=%h rd_cycles=%0d", done_k, rd_val, rd_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
# dmem_bus_arbiter

Shares the single data-memory port between the L1 data caches of `NUM_CORES` cores in the multicore build. It sits between the per-core L1 miss/write-through interfaces and the data memory. It grants one requester at a time, round-robin by default, and sequences each access through a fixed-latency memory transaction. The winner gets a one-cycle `done` pulse carrying its read data; the other requesters are held off.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of requesting L1 caches (2..8).
- `ADDR_W`, default 10: word address width ({tag, index}).
- `DATA_W`, default 32: data width.
- `MEM_LAT`, default 1: memory access cycles (1..15).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `req`  in  NUM_CORES  per-core request; held high until `done` for that core.
- `we`  in  NUM_CORES  per-core write (1) / read (0) qualifier.
- `addr`  in  NUM_CORES*ADDR_W  per-core word address; core i at slice i.
- `wdata`  in  NUM_CORES*DATA_W  per-core write data.
- `gnt`  out  NUM_CORES  one-hot owner of the memory port; registered.
- `done`  out  NUM_CORES  one-cycle completion pulse to the owner.
- `rdata`  out  DATA_W  read data; valid while any `done` bit is high.
- `mem_rd_en`  out  1  memory read enable.
- `mem_wr_en`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid in the last ACCESS cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when `req` != 0.
  - ACCESS → RESP when `lat_cnt` == MEM_LAT-1.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE only. The winner is the first set `req` bit, scanning from `rr_ptr` upward modulo NUM_CORES.
- On entering ACCESS:
  - the winner's `we`, `addr` and `wdata` are latched into `txn_*` registers;
  - `gnt` is set to the winner's one-hot;
  - `lat_cnt` is cleared.
- Requester inputs are ignored after the latch. `gnt` stays high through ACCESS and RESP.
- ACCESS cycles:
  - `mem_addr`/`mem_wdata` are driven from the `txn_*` registers.
  - `mem_rd_en` = !`txn_we` in every ACCESS cycle.
  - `mem_wr_en` = `txn_we` in the last ACCESS cycle only.
  - `lat_cnt` increments each cycle.
- Data capture: on the last ACCESS cycle, a read latches `mem_rdata` into `rdata_q`. A write leaves `rdata_q` unchanged.
- RESP cycle:
  - `done[owner]` = 1 and `rdata` = `rdata_q`.
  - `rr_ptr` ← (owner+1) mod NUM_CORES.
  - `gnt` clears on exit.
- Requester rule: sample `done` and drop `req` at that same clock edge. A `req` still high in the following IDLE cycle is treated as a new request.
- Requests arriving during ACCESS/RESP wait. No request is lost, and none is reordered beyond the round-robin order.
- Reset values (also apply on reset mid-transaction):
  - state = IDLE, `rr_ptr` = 0, `lat_cnt` = 0, `rdata_q` = 0;
  - all outputs 0.
  - An in-flight write is abandoned; the memory sees no `mem_wr_en` on or after the reset cycle.
- Outputs are don't-care-free: all memory outputs are 0 outside ACCESS, and `rdata` is 0 outside RESP.

## Timing
- The request is sampled in IDLE at cycle t.
- ACCESS occupies cycles t+1..t+MEM_LAT; RESP occupies cycle t+MEM_LAT+1.
- Latency from `req` to `done` is MEM_LAT+1 cycles when uncontended.
- Throughput is one transaction per MEM_LAT+2 cycles, since one IDLE cycle separates back-to-back grants.
- Worst-case wait for a requester: (NUM_CORES-1)*(MEM_LAT+2) cycles before its grant.
- Simultaneous requests in IDLE: exactly one grant, with the selection made purely combinationally from `req` and `rr_ptr`.

## Configuration
- `DMEM_ARB_FIXED_PRIORITY_EN`:
  - Defined: the winner is the lowest-index set `req` bit. `rr_ptr` is not implemented, and a continuously requesting core 0 can starve the others.
  - Undefined (default): round-robin as described above.

## Test plan
All scenarios use NUM_CORES=2 and MEM_LAT=1.
- Reset: all outputs are 0 and state is IDLE. Then core0 reads 0x005 with the memory returning 0xDEADBEEF → `gnt`=01 at t+1, `mem_rd_en`=1 and `mem_addr`=0x005 at t+1, `done`=01 and `rdata`=0xDEADBEEF at t+2.
- Core1 writes 0x3FF with data 0x12345678 → `mem_wr_en` high for exactly one cycle with `mem_wdata`=0x12345678, `done`=10 at t+2, `rdata`=0.
- Both cores request continuously after reset → grants alternate 01, 10, 01, 10 with 3-cycle spacing; with the macro defined, the grants are 01 every time.
- Core1 raises `req` while core0 is in ACCESS → core1 is granted in the IDLE following core0's RESP; core0's latched address is unaffected by core1's inputs.
- `reset` asserted during ACCESS of a core0 write → no `mem_wr_en` pulse, no `done`, IDLE the next cycle, and `rr_ptr`=0 (core0 wins the next tie).
- MEM_LAT=3 read → `mem_rd_en` high for 3 cycles, the value on the 3rd cycle is returned, and `done` arrives 4 cycles after `req`.
